// File: rtl/cam_cfg_seq.sv
// Camera sensor power-up configuration sequencer: enables the sensor, waits, then streams a register table to an I2C master.
// Optional read-back verification of each write is compiled in with `define CAM_CFG_READBACK_EN.
module cam_cfg_seq #(
    parameter int         NUM_ENTRIES  = 64,
    parameter logic [6:0] DEV_ADDR     = 7'h10,
    parameter int         PWRUP_CYC    = 500_000,
    parameter int         DLY_UNIT_CYC = 50_000,
    parameter int         RETRY_MAX    = 3,
    localparam int        AW           = $clog2(NUM_ENTRIES)
) (
    input  logic          i_clk,
    input  logic          i_arst_n,
    input  logic          i_start,
    output logic          o_cam_en,
    output logic [AW-1:0] o_rom_addr,
    input  logic [23:0]   i_rom_data,
    output logic          o_cmd_valid,
    input  logic          i_cmd_ready,
    output logic [6:0]    o_cmd_dev,
    output logic [15:0]   o_cmd_reg,
    output logic [7:0]    o_cmd_wdat,
    output logic          o_cmd_rnw,
    input  logic          i_rsp_valid,
    input  logic          i_rsp_nack,
    input  logic [7:0]    i_rsp_rdat,
    output logic          o_busy,
    output logic          o_cfg_done,
    output logic          o_cfg_err,
    output logic [AW-1:0] o_err_idx
);

    localparam int DLY_MAX = 255 * DLY_UNIT_CYC;
    localparam int TMAX    = (PWRUP_CYC > DLY_MAX) ? PWRUP_CYC : DLY_MAX;
    localparam int TW      = $clog2(TMAX + 1);
    localparam int RW      = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

    // FETCH and DECODE take the last two power-up cycles, so the first
    // command appears exactly PWRUP_CYC cycles after cam_en rises.
    localparam logic [TW-1:0] PWRUP_LAST = TW'(PWRUP_CYC - 3);
    localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_ENTRIES - 1);
    localparam logic [RW-1:0] RETRY_LIM  = RW'(RETRY_MAX);

    typedef enum logic [3:0] {
        S_IDLE, S_PWRUP, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DELAY, S_DONE, S_ERROR
    } state_t;

    state_t          r_state, w_state_next;
    logic [AW-1:0]   r_idx, w_idx_next;
    logic [RW-1:0]   r_retry, w_retry_next;
    logic [TW-1:0]   r_timer, w_timer_next;
    logic [15:0]     r_cmd_reg, w_cmd_reg_next;
    logic [7:0]      r_cmd_wdat, w_cmd_wdat_next;
    logic [6:0]      r_cmd_dev, w_cmd_dev_next;
    logic [AW-1:0]   r_err_idx, w_err_idx_next;
    logic            r_rnw, w_rnw_next;
    logic            w_advance;
    logic            w_rsp_ok;
    logic            w_rd_pending;

    logic [15:0]     w_rom_reg;
    logic [7:0]      w_rom_dat;
    logic [TW-1:0]   w_dly_cyc;

    assign w_rom_reg = i_rom_data[23:8];
    assign w_rom_dat = i_rom_data[7:0];
    assign w_dly_cyc = TW'(w_rom_dat) * TW'(DLY_UNIT_CYC);

`ifdef CAM_CFG_READBACK_EN
    // A write is only complete once the read-back phase returns matching data.
    assign w_rsp_ok     = !i_rsp_nack && (!r_rnw || (i_rsp_rdat == r_cmd_wdat));
    assign w_rd_pending = !r_rnw;
`else
    logic w_unused_rdat;
    assign w_unused_rdat = ^i_rsp_rdat;
    assign w_rsp_ok      = !i_rsp_nack;
    assign w_rd_pending  = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_retry    <= '0;
            r_timer    <= '0;
            r_cmd_reg  <= '0;
            r_cmd_wdat <= '0;
            r_cmd_dev  <= '0;
            r_err_idx  <= '0;
            r_rnw      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_retry    <= w_retry_next;
            r_timer    <= w_timer_next;
            r_cmd_reg  <= w_cmd_reg_next;
            r_cmd_wdat <= w_cmd_wdat_next;
            r_cmd_dev  <= w_cmd_dev_next;
            r_err_idx  <= w_err_idx_next;
            r_rnw      <= w_rnw_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_retry_next    = r_retry;
        w_timer_next    = r_timer;
        w_cmd_reg_next  = r_cmd_reg;
        w_cmd_wdat_next = r_cmd_wdat;
        w_cmd_dev_next  = r_cmd_dev;
        w_err_idx_next  = r_err_idx;
        w_rnw_next      = r_rnw;
        w_advance       = 1'b0;

        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    w_state_next = S_PWRUP;
                    w_idx_next   = '0;
                    w_retry_next = '0;
                    w_timer_next = '0;
                    w_rnw_next   = 1'b0;
                end
            end
            S_PWRUP: begin
                if (r_timer >= PWRUP_LAST) begin
                    w_state_next = S_FETCH;
                    w_timer_next = '0;
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            S_FETCH: w_state_next = S_DECODE;
            S_DECODE: begin
                if (w_rom_reg == 16'hFFFF) begin
                    if (w_rom_dat == 8'd0) begin
                        w_advance = 1'b1;
                    end else begin
                        w_timer_next = w_dly_cyc;
                        w_state_next = S_DELAY;
                    end
                end else if (w_rom_reg == 16'hFFFE) begin
                    w_state_next = S_DONE;
                end else begin
                    w_cmd_reg_next  = w_rom_reg;
                    w_cmd_wdat_next = w_rom_dat;
                    w_cmd_dev_next  = DEV_ADDR;
                    w_rnw_next      = 1'b0;
                    w_state_next    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_cmd_ready) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_rsp_valid) begin
                    if (w_rsp_ok && w_rd_pending) begin
                        w_rnw_next   = 1'b1;
                        w_state_next = S_ISSUE;
                    end else if (w_rsp_ok) begin
                        w_retry_next = '0;
                        w_rnw_next   = 1'b0;
                        w_advance    = 1'b1;
                    end else if (r_retry < RETRY_LIM) begin
                        // every retry restarts from the write phase
                        w_retry_next = r_retry + RW'(1);
                        w_rnw_next   = 1'b0;
                        w_state_next = S_ISSUE;
                    end else begin
                        w_err_idx_next = r_idx;
                        w_rnw_next     = 1'b0;
                        w_state_next   = S_ERROR;
                    end
                end
            end
            S_DELAY: begin
                if (r_timer <= TW'(1)) begin
                    w_timer_next = '0;
                    w_advance    = 1'b1;
                end else begin
                    w_timer_next = r_timer - TW'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // The table ends implicitly at its last slot; the index never wraps.
        if (w_advance) begin
            if (r_idx == IDX_LAST) begin
                w_state_next = S_DONE;
            end else begin
                w_idx_next   = r_idx + AW'(1);
                w_state_next = S_FETCH;
            end
        end
    end

    assign o_cam_en    = (r_state != S_IDLE) && (r_state != S_ERROR);
    assign o_busy      = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
    assign o_cfg_done  = (r_state == S_DONE);
    assign o_cfg_err   = (r_state == S_ERROR);
    assign o_cmd_valid = (r_state == S_ISSUE);
    assign o_rom_addr  = r_idx;
    assign o_cmd_dev   = r_cmd_dev;
    assign o_cmd_reg   = r_cmd_reg;
    assign o_cmd_wdat  = r_cmd_wdat;
    assign o_cmd_rnw   = r_rnw;
    assign o_err_idx   = r_err_idx;

endmodule

// File: tb/tb_cam_cfg_seq.sv
// Directed bench for cam_cfg_seq: short power-up/delay timings, an 8-entry instance for the
// main scenarios and a 4-entry instance for the table without an end marker.
module tb_cam_cfg_seq;

    localparam int P    = 20;
    localparam int U    = 10;
    localparam int NE   = 8;
    localparam int WMAX = 300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n;
    logic        start, cmd_ready, rsp_valid, rsp_nack;
    logic [7:0]  rsp_rdat;
    logic [23:0] rom_data;
    logic        cam_en, cmd_valid, cmd_rnw, busy, cfg_done, cfg_err;
    logic [2:0]  rom_addr, err_idx;
    logic [6:0]  cmd_dev;
    logic [15:0] cmd_reg;
    logic [7:0]  cmd_wdat;

    logic        b_start, b_cmd_ready, b_rsp_valid, b_rsp_nack;
    logic [7:0]  b_rsp_rdat;
    logic [23:0] b_rom_data;
    logic        b_cam_en, b_cmd_valid, b_cmd_rnw, b_busy, b_cfg_done, b_cfg_err;
    logic [1:0]  b_rom_addr, b_err_idx;
    logic [6:0]  b_cmd_dev;
    logic [15:0] b_cmd_reg;
    logic [7:0]  b_cmd_wdat;

    logic [23:0] tbl   [NE];
    logic [23:0] tbl_b [4];

    int n_checks = 0;
    int n_err    = 0;
    int acc_cnt  = 0;
    int b_acc    = 0;

    cam_cfg_seq #(.NUM_ENTRIES(NE), .DEV_ADDR(7'h10), .PWRUP_CYC(P),
                  .DLY_UNIT_CYC(U), .RETRY_MAX(3)) u_dut (
        .i_clk(clk), .i_arst_n(arst_n), .i_start(start), .o_cam_en(cam_en),
        .o_rom_addr(rom_addr), .i_rom_data(rom_data), .o_cmd_valid(cmd_valid),
        .i_cmd_ready(cmd_ready), .o_cmd_dev(cmd_dev), .o_cmd_reg(cmd_reg),
        .o_cmd_wdat(cmd_wdat), .o_cmd_rnw(cmd_rnw), .i_rsp_valid(rsp_valid),
        .i_rsp_nack(rsp_nack), .i_rsp_rdat(rsp_rdat), .o_busy(busy),
        .o_cfg_done(cfg_done), .o_cfg_err(cfg_err), .o_err_idx(err_idx)
    );

    cam_cfg_seq #(.NUM_ENTRIES(4), .DEV_ADDR(7'h10), .PWRUP_CYC(P),
                  .DLY_UNIT_CYC(U), .RETRY_MAX(3)) u_dut4 (
        .i_clk(clk), .i_arst_n(arst_n), .i_start(b_start), .o_cam_en(b_cam_en),
        .o_rom_addr(b_rom_addr), .i_rom_data(b_rom_data), .o_cmd_valid(b_cmd_valid),
        .i_cmd_ready(b_cmd_ready), .o_cmd_dev(b_cmd_dev), .o_cmd_reg(b_cmd_reg),
        .o_cmd_wdat(b_cmd_wdat), .o_cmd_rnw(b_cmd_rnw), .i_rsp_valid(b_rsp_valid),
        .i_rsp_nack(b_rsp_nack), .i_rsp_rdat(b_rsp_rdat), .o_busy(b_busy),
        .o_cfg_done(b_cfg_done), .o_cfg_err(b_cfg_err), .o_err_idx(b_err_idx)
    );

    // Table memories with one cycle of read latency
    always @(posedge clk) rom_data   <= tbl[rom_addr];
    always @(posedge clk) b_rom_data <= tbl_b[b_rom_addr];

    always @(posedge clk) if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
    always @(posedge clk) if (b_cmd_valid && b_cmd_ready) b_acc <= b_acc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic start_seq();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_cmd(output int n);
        n = 0;
        while (cmd_valid !== 1'b1 && n < WMAX) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_wait_timeout", 32'(n >= WMAX), 0);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (cfg_done !== 1'b1 && cfg_err !== 1'b1 && n < WMAX) begin
            @(negedge clk);
            n++;
        end
        chk("end_wait_timeout", 32'(n >= WMAX), 0);
    endtask

    task automatic serve(input int hold, input bit nack, input bit do_rsp,
                         input logic [15:0] exp_reg, input logic [7:0] exp_dat);
        int n;
        wait_cmd(n);
        chk("cmd_reg", cmd_reg, exp_reg);
        chk("cmd_wdat", cmd_wdat, exp_dat);
        chk("cmd_dev", cmd_dev, 7'h10);
        chk("cmd_rnw", cmd_rnw, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", cmd_valid, 1);
            chk("hold_reg", cmd_reg, exp_reg);
            chk("hold_wdat", cmd_wdat, exp_dat);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        chk("valid_drop", cmd_valid, 0);
        if (do_rsp) begin
            rsp_valid = 1'b1;
            rsp_nack  = nack;
            @(negedge clk);
            rsp_valid = 1'b0;
            rsp_nack  = 1'b0;
        end
    endtask

    initial begin
        int n;
        int acc0;
        bit seen;

        arst_n = 1'b0;
        start = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_rdat = 8'h00;
        b_start = 1'b0; b_cmd_ready = 1'b0; b_rsp_valid = 1'b0; b_rsp_nack = 1'b0; b_rsp_rdat = 8'h00;
        tbl[0] = 24'h0100_00; tbl[1] = 24'hFFFF_02; tbl[2] = 24'h0100_01;
        for (int i = 3; i < NE; i++) tbl[i] = 24'hFFFE_00;
        for (int i = 0; i < 4; i++) tbl_b[i] = {16'h4000 + 16'(i), 8'(i + 1)};

        repeat (3) @(negedge clk);
        chk("reset_flags", {26'd0, cam_en, cmd_valid, busy, cfg_done, cfg_err, cmd_rnw}, 0);
        chk("reset_idx", {26'd0, err_idx, rom_addr}, 0);
        chk("reset_cmd", {1'b0, cmd_dev, cmd_reg, cmd_wdat}, 0);
        chk("reset_b_flags", {28'd0, b_cam_en, b_cmd_valid, b_busy, b_cfg_done}, 0);
        @(negedge clk); arst_n = 1'b1;

        // Basic table: write, 2-unit delay, write, end marker
        acc0 = acc_cnt;
        start_seq();
        chk("t1_cam_en", cam_en, 1);
        chk("t1_busy", busy, 1);
        wait_cmd(n);
        chk("t1_pwrup_cycles", n, P);
        serve(10, 1'b0, 1'b1, 16'h0100, 8'h00);
        wait_cmd(n);
        chk("t1_delay_gap_ok", 32'(n >= 2 * U), 1);
        serve(0, 1'b0, 1'b1, 16'h0100, 8'h01);
        wait_end();
        chk("t1_done", cfg_done, 1);
        chk("t1_err", cfg_err, 0);
        chk("t1_busy_end", busy, 0);
        chk("t1_cam_en_end", cam_en, 1);
        chk("t1_accepts", acc_cnt - acc0, 2);

        // Entry 2 NACKed twice then ACKed
        for (int i = 0; i < 7; i++) tbl[i] = {16'h3000 + 16'(i), 8'(17 * (i + 1))};
        tbl[7] = 24'hFFFE_00;
        acc0 = acc_cnt;
        start_seq();
        chk("t2_done_cleared", cfg_done, 0);
        for (int e = 0; e < 7; e++) begin
            int nk;
            nk = (e == 2) ? 2 : 0;
            for (int k = 0; k <= nk; k++)
                serve(0, (k < nk), 1'b1, 16'h3000 + 16'(e), 8'(17 * (e + 1)));
        end
        wait_end();
        chk("t2_done", cfg_done, 1);
        chk("t2_err", cfg_err, 0);
        chk("t2_accepts", acc_cnt - acc0, 9);

        // Entry 5 NACKed four times
        acc0 = acc_cnt;
        start_seq();
        for (int e = 0; e < 5; e++) serve(0, 1'b0, 1'b1, 16'h3000 + 16'(e), 8'(17 * (e + 1)));
        for (int k = 0; k < 4; k++) serve(0, 1'b1, 1'b1, 16'h3005, 8'h66);
        chk("t3_cfg_err", cfg_err, 1);
        chk("t3_err_idx", err_idx, 5);
        chk("t3_cam_en", cam_en, 0);
        chk("t3_busy", busy, 0);
        chk("t3_done", cfg_done, 0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_valid === 1'b1) seen = 1'b1;
        end
        chk("t3_no_cmd_after_err", seen, 0);
        chk("t3_accepts", acc_cnt - acc0, 9);

        // Reset while waiting for the response to entry 2
        start_seq();
        chk("t4_err_cleared", cfg_err, 0);
        serve(0, 1'b0, 1'b1, 16'h3000, 8'h11);
        serve(0, 1'b0, 1'b1, 16'h3001, 8'h22);
        serve(0, 1'b0, 1'b0, 16'h3002, 8'h33);
        #2 arst_n = 1'b0;
        #1;
        chk("t4_rst_flags", {27'd0, cam_en, cmd_valid, busy, cfg_done, cfg_err}, 0);
        chk("t4_rst_rom_addr", rom_addr, 0);
        chk("t4_rst_cmd", {8'd0, cmd_reg, cmd_wdat}, 0);
        @(negedge clk); arst_n = 1'b1;
        start_seq();
        wait_cmd(n);
        chk("t4_pwrup_cycles", n, P);
        for (int e = 0; e < 7; e++) serve(0, 1'b0, 1'b1, 16'h3000 + 16'(e), 8'(17 * (e + 1)));
        wait_end();
        chk("t4_done", cfg_done, 1);

        // Four-entry table without an end marker
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (b_cmd_valid !== 1'b1 && n < WMAX) begin
                @(negedge clk);
                n++;
            end
            chk("t5_wait_timeout", 32'(n >= WMAX), 0);
            chk("t5_cmd_reg", b_cmd_reg, 16'h4000 + 16'(i));
            chk("t5_cmd_wdat", b_cmd_wdat, 8'(i + 1));
            b_cmd_ready = 1'b1;
            @(negedge clk); b_cmd_ready = 1'b0;
            b_rsp_valid = 1'b1;
            @(negedge clk); b_rsp_valid = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (b_cmd_valid === 1'b1) seen = 1'b1;
        end
        chk("t5_no_extra_cmd", seen, 0);
        chk("t5_accepts", b_acc, 4);
        chk("t5_done", b_cfg_done, 1);
        chk("t5_err", {b_cfg_err, b_err_idx}, 0);
        chk("t5_rom_addr_last", b_rom_addr, 3);
        chk("t5_busy_cam", {b_busy, b_cam_en, b_cmd_rnw}, 3'b010);
        chk("t5_cmd_dev", b_cmd_dev, 7'h10);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
